// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, ALU opcode encoding and forwarding selects.
package cpu_pkg;

  localparam int unsigned DEFAULT_XLEN       = 32;
  localparam int unsigned DEFAULT_REG_ADDR_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/writeback logic and the ID/EX stage.
interface id_ex_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic                  id_alu_src_imm;
  logic [3:0]            id_alu_control;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  flush;
  logic                  exmem_reg_write;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic [XLEN-1:0]       exmem_result;
  logic                  memwb_reg_write;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic [XLEN-1:0]       memwb_result;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [3:0]            alu_control;
  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [XLEN-1:0]       ex_store_data;
  logic                  stall_id;

  modport master (
    output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src_imm, id_alu_control, id_reg_write, id_mem_read, id_mem_write, flush,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    input  alu_a, alu_b, alu_control, ex_valid, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, stall_id
  );

  modport slave (
    input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_src_imm, id_alu_control, id_reg_write, id_mem_read, id_mem_write, flush,
           exmem_reg_write, exmem_rd, exmem_result, memwb_reg_write, memwb_rd, memwb_result,
    output alu_a, alu_b, alu_control, ex_valid, ex_pc, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_store_data, stall_id
  );
endinterface

// File: rtl/forward_unit.sv
// Picks the freshest source for one operand register; EX/MEM beats MEM/WB, x0 never forwards.
module forward_unit
  import cpu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  output fwd_sel_t              sel
);

  always_comb begin
    sel = FWD_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall generation.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN       = DEFAULT_XLEN,
  parameter int unsigned REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic                  ex_valid;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [XLEN-1:0]       ex_rs1_data;
  logic [XLEN-1:0]       ex_rs2_data;
  logic [XLEN-1:0]       ex_imm;
  logic                  ex_alu_src_imm;
  logic [3:0]            ex_alu_control;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;

  logic                  stall_id;
  logic                  rs1_hit;
  logic                  rs2_hit;
  fwd_sel_t              sel_rs1;
  fwd_sel_t              sel_rs2;
  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;

  // Load in EX whose result is needed by the instruction in ID cannot be forwarded in time.
  assign rs1_hit  = (bus.id_rs1 == ex_rd);
  assign rs2_hit  = (bus.id_rs2 == ex_rd);
  assign stall_id = !bus.flush && ex_valid && ex_mem_read && (ex_rd != '0) && bus.id_valid &&
                    (rs1_hit || (rs2_hit && !bus.id_alu_src_imm) ||
                     (rs2_hit && bus.id_mem_write));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1         <= '0;
      ex_rs2         <= '0;
      ex_rd          <= '0;
      ex_rs1_data    <= '0;
      ex_rs2_data    <= '0;
      ex_imm         <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_alu_control <= ALU_ADD;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
    end else if (bus.flush || stall_id) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= ALU_ADD;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
    end else begin
      ex_valid       <= bus.id_valid;
      ex_pc          <= bus.id_pc;
      ex_rs1         <= bus.id_rs1;
      ex_rs2         <= bus.id_rs2;
      ex_rd          <= bus.id_rd;
      ex_rs1_data    <= bus.id_rs1_data;
      ex_rs2_data    <= bus.id_rs2_data;
      ex_imm         <= bus.id_imm;
      ex_alu_src_imm <= bus.id_alu_src_imm;
      ex_alu_control <= bus.id_alu_control;
      ex_reg_write   <= bus.id_reg_write & bus.id_valid;
      ex_mem_read    <= bus.id_mem_read & bus.id_valid;
      ex_mem_write   <= bus.id_mem_write & bus.id_valid;
    end
  end

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .rs              (ex_rs1),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .sel             (sel_rs1)
  );

  forward_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .rs              (ex_rs2),
    .exmem_reg_write (bus.exmem_reg_write),
    .exmem_rd        (bus.exmem_rd),
    .memwb_reg_write (bus.memwb_reg_write),
    .memwb_rd        (bus.memwb_rd),
    .sel             (sel_rs2)
  );

  always_comb begin
    fwd_rs1 = ex_rs1_data;
    unique case (sel_rs1)
      FWD_EXMEM: fwd_rs1 = bus.exmem_result;
      FWD_MEMWB: fwd_rs1 = bus.memwb_result;
      default:   fwd_rs1 = ex_rs1_data;
    endcase
  end

  always_comb begin
    fwd_rs2 = ex_rs2_data;
    unique case (sel_rs2)
      FWD_EXMEM: fwd_rs2 = bus.exmem_result;
      FWD_MEMWB: fwd_rs2 = bus.memwb_result;
      default:   fwd_rs2 = ex_rs2_data;
    endcase
  end

  assign bus.alu_a         = ex_valid ? fwd_rs1 : '0;
  assign bus.alu_b         = ex_valid ? (ex_alu_src_imm ? ex_imm : fwd_rs2) : '0;
  assign bus.alu_control   = ex_alu_control;
  assign bus.ex_valid      = ex_valid;
  assign bus.ex_pc         = ex_pc;
  assign bus.ex_rd         = ex_rd;
  assign bus.ex_reg_write  = ex_reg_write;
  assign bus.ex_mem_read   = ex_mem_read;
  assign bus.ex_mem_write  = ex_mem_write;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.stall_id      = stall_id;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, issue, forwarding, immediates, load-use and flush.
module tb_id_ex_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_stage #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic id_instr(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src_imm, input logic [3:0] ctl,
                          input logic rw, input logic mr, input logic mw);
    bus.id_valid       = v;
    bus.id_pc          = pc;
    bus.id_rs1         = rs1;
    bus.id_rs2         = rs2;
    bus.id_rd          = rd;
    bus.id_rs1_data    = d1;
    bus.id_rs2_data    = d2;
    bus.id_imm         = imm;
    bus.id_alu_src_imm = src_imm;
    bus.id_alu_control = ctl;
    bus.id_reg_write   = rw;
    bus.id_mem_read    = mr;
    bus.id_mem_write   = mw;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write = ew;
    bus.exmem_rd        = erd;
    bus.exmem_result    = eres;
    bus.memwb_reg_write = mw;
    bus.memwb_rd        = mrd;
    bus.memwb_result    = mres;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.flush = 1'b0;
    id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Reset state
    tick();
    chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_alu_ctl", {28'd0, bus.alu_control}, 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_stall", {31'd0, bus.stall_id}, 32'd0);
    rst_n = 1'b1;

    // Plain issue: ADD x3 = x1 + x2
    id_instr(1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd15, 32'd25, 32'd0, 0, 4'b0000, 1, 0, 0);
    tick();
    chk("plain_alu_a", bus.alu_a, 32'd15);
    chk("plain_alu_b", bus.alu_b, 32'd25);
    chk("plain_ctl", {28'd0, bus.alu_control}, 32'd0);
    chk("plain_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("plain_pc", bus.ex_pc, 32'h100);
    chk("plain_rd", {27'd0, bus.ex_rd}, 32'd3);
    chk("plain_rw", {31'd0, bus.ex_reg_write}, 32'd1);
    chk("plain_stall", {31'd0, bus.stall_id}, 32'd0);

    // Dual forward priority on rs1=3
    id_instr(1, 32'h104, 5'd3, 5'd4, 5'd6, 32'h11, 32'h22, 32'd0, 0, 4'b0001, 1, 0, 0);
    tick();
    set_fwd(1, 5'd3, 32'h40, 1, 5'd3, 32'h99);
    #1;
    chk("fwd_both_a", bus.alu_a, 32'h40);
    chk("fwd_both_b", bus.alu_b, 32'h22);
    chk("fwd_sub_ctl", {28'd0, bus.alu_control}, 32'd1);
    set_fwd(0, 5'd3, 32'h40, 1, 5'd3, 32'h99);
    #1;
    chk("fwd_memwb_a", bus.alu_a, 32'h99);
    set_fwd(1, 5'd0, 32'd7, 1, 5'd0, 32'h99);
    #1;
    chk("fwd_x0_a", bus.alu_a, 32'h11);

    // Immediate select with forwarded store data
    id_instr(1, 32'h108, 5'd7, 5'd4, 5'd0, 32'h7, 32'h22, 32'hFFFF_FFFC, 1, 4'b0000, 0, 0, 1);
    tick();
    set_fwd(1, 5'd4, 32'h55, 0, 5'd0, 32'd0);
    #1;
    chk("imm_alu_b", bus.alu_b, 32'hFFFF_FFFC);
    chk("imm_store", bus.ex_store_data, 32'h55);
    chk("imm_alu_a", bus.alu_a, 32'h7);
    chk("imm_mw", {31'd0, bus.ex_mem_write}, 32'd1);
    chk("imm_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    // Load-use: load x5, then consumer of x5
    set_fwd(0, 0, 0, 0, 0, 0);
    id_instr(1, 32'h10C, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd8, 1, 4'b0000, 1, 1, 0);
    tick();
    chk("ld_mr", {31'd0, bus.ex_mem_read}, 32'd1);
    id_instr(1, 32'h110, 5'd5, 5'd2, 5'd9, 32'd0, 32'd3, 32'd0, 0, 4'b0000, 1, 0, 0);
    #1;
    chk("lu_stall", {31'd0, bus.stall_id}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, bus.ex_reg_write}, 32'd0);
    chk("lu_bubble_mr", {31'd0, bus.ex_mem_read}, 32'd0);
    chk("lu_bubble_a", bus.alu_a, 32'd0);
    chk("lu_bubble_stall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    set_fwd(0, 0, 0, 1, 5'd5, 32'hABC);
    #1;
    chk("lu_issue_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("lu_issue_a", bus.alu_a, 32'hABC);
    chk("lu_issue_b", bus.alu_b, 32'd3);
    chk("lu_issue_rd", {27'd0, bus.ex_rd}, 32'd9);

    // Flush overrides a load-use stall
    set_fwd(0, 0, 0, 0, 0, 0);
    id_instr(1, 32'h114, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd8, 1, 4'b0000, 1, 1, 0);
    tick();
    id_instr(1, 32'h118, 5'd5, 5'd2, 5'd9, 32'd0, 32'd3, 32'd0, 0, 4'b0000, 1, 0, 0);
    #1;
    chk("fl_pre_stall", {31'd0, bus.stall_id}, 32'd1);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", {31'd0, bus.stall_id}, 32'd0);
    tick();
    bus.flush = 1'b0;
    chk("fl_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("fl_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    // Store data dependency on a load stalls; an imm-only rs2 does not
    id_instr(1, 32'h11C, 5'd1, 5'd0, 5'd5, 32'h1000, 32'd0, 32'd8, 1, 4'b0000, 1, 1, 0);
    tick();
    id_instr(1, 32'h120, 5'd1, 5'd5, 5'd0, 32'h1000, 32'd0, 32'd4, 1, 4'b0000, 0, 0, 1);
    #1;
    chk("st_stall", {31'd0, bus.stall_id}, 32'd1);
    bus.id_mem_write = 1'b0;
    #1;
    chk("imm_no_stall", {31'd0, bus.stall_id}, 32'd0);

    // Mid-run asynchronous reset
    id_instr(1, 32'h124, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'd0, 0, 4'b0100, 1, 0, 0);
    tick();
    chk("pre_rst_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("pre_rst_ctl", {28'd0, bus.alu_control}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("mid_rst_ctl", {28'd0, bus.alu_control}, 32'd0);
    chk("mid_rst_a", bus.alu_a, 32'd0);
    chk("mid_rst_b", bus.alu_b, 32'd0);
    chk("mid_rst_stall", {31'd0, bus.stall_id}, 32'd0);
    chk("mid_rst_rw", {31'd0, bus.ex_reg_write}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
